// File: rtl/des_ahb_master.sv
// des_ahb_master: AHB-Lite initiator that loads a Triple DES job into the slave,
// polls its done flag and returns the result block on a valid/ready interface.
module des_ahb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] KEY1_OFF  = 32'h00,
   parameter logic [31:0] KEY2_OFF  = 32'h08,
   parameter logic [31:0] KEY3_OFF  = 32'h10,
   parameter logic [31:0] DATA_OFF  = 32'h18,
   parameter logic [31:0] CTRL_OFF  = 32'h20,
   parameter logic [31:0] STAT_OFF  = 32'h28,
   parameter logic [31:0] RES_OFF   = 32'h30,
   parameter int          POLL_MAX  = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic        encr_decr,
   input  logic [63:0] in_data,
   input  logic [63:0] key1,
   input  logic [63:0] key2,
   input  logic [63:0] key3,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [63:0] result_data,
   output logic        result_error,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HBURST,
   output logic [2:0]  HSIZE,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [63:0] HWDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   input  logic [63:0] HRDATA
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
   typedef enum logic [2:0] {W_KEY1, W_KEY2, W_KEY3, W_DATA, W_CTRL, R_STAT, R_RES} step_t;
   state_t      state;
   step_t       step, nxt_step;
   logic [63:0] k1_q, k2_q, k3_q, data_q, wdata;
   logic        enc_q, timeout;
   logic [15:0] poll_cnt;
   logic [31:0] nxt_addr;
   assign start_ready = state == IDLE;
   assign HBURST      = 3'b000;
   assign HSIZE       = 3'b011;
   assign HPROT       = 4'b0011;
   assign HMASTLOCK   = 1'b0;
   always_comb begin
      nxt_step = step == R_STAT ? (HRDATA[0] ? R_RES : R_STAT) : step_t'(step + 3'd1);
      nxt_addr = BASE_ADDR + (nxt_step == W_KEY1 ? KEY1_OFF :
                              nxt_step == W_KEY2 ? KEY2_OFF :
                              nxt_step == W_KEY3 ? KEY3_OFF :
                              nxt_step == W_DATA ? DATA_OFF :
                              nxt_step == W_CTRL ? CTRL_OFF :
                              nxt_step == R_STAT ? STAT_OFF : RES_OFF);
      wdata    = step == W_KEY1 ? k1_q :
                 step == W_KEY2 ? k2_q :
                 step == W_KEY3 ? k3_q :
                 step == W_DATA ? data_q :
                 step == W_CTRL ? {62'b0, enc_q, 1'b1} : 64'b0;
      // the final unsuccessful poll is the POLL_MAX-th status read
      timeout  = step == R_STAT && !HRDATA[0] && poll_cnt == 16'(POLL_MAX - 1);
   end
   always_ff @(posedge HCLK) begin
      if (!HRESET) begin
         state        <= IDLE;
         step         <= W_KEY1;
         HTRANS       <= 2'b00;
         HADDR        <= '0;
         HWRITE       <= 1'b0;
         HWDATA       <= '0;
         result_valid <= 1'b0;
         result_data  <= '0;
         result_error <= 1'b0;
         poll_cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (start_valid) begin
               k1_q     <= key1;
               k2_q     <= key2;
               k3_q     <= key3;
               data_q   <= in_data;
               enc_q    <= encr_decr;
               poll_cnt <= '0;
               step     <= W_KEY1;
               HTRANS   <= 2'b10;
               HADDR    <= BASE_ADDR + KEY1_OFF;
               HWRITE   <= 1'b1;
               state    <= ADDR;
            end
            ADDR: if (HREADY) begin
               HTRANS <= 2'b00;
               HWDATA <= wdata;
               state  <= DATA;
            end
            DATA: if (HREADY) begin
               if (step == R_STAT && !HRDATA[0]) poll_cnt <= poll_cnt + 16'd1;
               if (HRESP || timeout) begin
                  result_valid <= 1'b1;
                  result_error <= 1'b1;
                  result_data  <= '0;
                  state        <= RESP;
               end else if (step == R_RES) begin
                  result_valid <= 1'b1;
                  result_error <= 1'b0;
                  result_data  <= HRDATA;
                  state        <= RESP;
               end else begin
                  step   <= nxt_step;
                  HTRANS <= 2'b10;
                  HADDR  <= nxt_addr;
                  HWRITE <= nxt_step < R_STAT;
                  state  <= ADDR;
               end
            end
            RESP: if (result_ready) begin
               result_valid <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_des_ahb_master.sv
// tb_des_ahb_master: randomized jobs against a behavioural AHB slave, with bus
// transfers and results checked from scoreboard queues filled at job accept.
module tb_des_ahb_master;
   localparam logic [31:0] BASE     = 32'h4000_0000;
   localparam int          POLL_MAX = 16;
   logic        HCLK = 0, HRESET = 0;
   logic        start_valid = 0, start_ready, encr_decr = 0;
   logic [63:0] in_data = '0, key1 = '0, key2 = '0, key3 = '0;
   logic        result_valid, result_ready = 1, result_error;
   logic [63:0] result_data;
   logic [31:0] HADDR;
   logic        HWRITE, HMASTLOCK;
   logic [1:0]  HTRANS;
   logic [2:0]  HBURST, HSIZE;
   logic [3:0]  HPROT;
   logic [63:0] HWDATA, HRDATA;
   logic        HREADY, HRESP;

   des_ahb_master #(.BASE_ADDR(BASE), .POLL_MAX(POLL_MAX)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .start_valid(start_valid), .start_ready(start_ready),
      .encr_decr(encr_decr), .in_data(in_data), .key1(key1), .key2(key2), .key3(key3),
      .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
      .result_error(result_error), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
      .HBURST(HBURST), .HSIZE(HSIZE), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA));

   always #5 HCLK = ~HCLK;

   typedef struct {logic [31:0] addr; logic wr; logic [63:0] wd;} xfer_t;
   typedef struct {logic [63:0] d; logic e; int t;} res_t;
   xfer_t exp_bus[$];
   res_t  exp_res[$];
   int    checks = 0, errors = 0, cyc = 0;

   // slave behaviour knobs for the job in flight
   int          wait_idx = -1, nwait = 0, err_idx = -1, done_at = 0, xn = 0, pn = 0;
   logic [63:0] res_val = '0;
   bit          dp = 0, pw = 0, perr = 0, wd_seen = 0;
   int          wl = 0;
   logic [31:0] pa = '0;
   logic [63:0] wd0 = '0;

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s bound expired", nm);
   endtask

   initial forever @(posedge HCLK) cyc++;

   // slave: decides this cycle's response at the negedge, tracks the transfer the master placed
   initial begin
      xfer_t       x;
      logic [63:0] rd;
      HREADY = 1;
      HRESP  = 0;
      HRDATA = '0;
      forever begin
         @(negedge HCLK);
         if (!HRESET) begin
            dp     = 0;
            HREADY = 1;
            HRESP  = 0;
         end else begin
            if (dp) begin
               chk("htrans_idle_in_data", 64'(HTRANS), 64'd0);
               if (pw && wd_seen) chk("hwdata_hold", HWDATA, wd0);
               if (pw && !wd_seen) begin wd0 = HWDATA; wd_seen = 1; end
               HRESP  = perr;
               HREADY = wl == 0;
               if (wl > 0) wl--;
               rd = r64();
               if (pa == BASE + 32'h28) rd[0] = pn >= done_at;
               else if (pa == BASE + 32'h30) rd = res_val;
               HRDATA = rd;
               if (HREADY) begin
                  if (exp_bus.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_xfer got addr=%h write=%0d want none", pa, pw);
                  end else begin
                     x = exp_bus.pop_front();
                     chk("xfer_addr", 64'(pa), 64'(x.addr));
                     chk("xfer_write", 64'(pw), 64'(x.wr));
                     if (x.wr) chk("xfer_wdata", HWDATA, x.wd);
                  end
                  if (pa == BASE + 32'h28) pn++;
                  xn++;
                  dp = 0;
               end
            end else begin
               HREADY = 1;
               HRESP  = 0;
               HRDATA = r64();
            end
            if (HTRANS == 2'b10 && HREADY) begin
               dp      = 1;
               pa      = HADDR;
               pw      = HWRITE;
               perr    = xn == err_idx;
               wl      = perr ? 1 : (xn == wait_idx ? nwait : 0);
               wd_seen = 0;
            end
         end
      end
   end

   // result monitor
   initial begin
      bit          pv = 0;
      logic [63:0] hd = '0;
      logic        he = 0;
      res_t        r;
      forever begin
         @(negedge HCLK);
         if (!HRESET) pv = 0;
         else begin
            if (result_valid && !pv) begin
               if (exp_res.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result got data=%h want none", result_data);
               end else chk("res_latency", 64'(cyc), 64'(exp_res[0].t));
            end
            if (pv) begin
               chk("res_hold_valid", 64'(result_valid), 64'd1);
               chk("res_hold_data", result_data, hd);
               chk("res_hold_err", 64'(result_error), 64'(he));
            end
            if (result_valid && result_ready && exp_res.size() != 0) begin
               r = exp_res.pop_front();
               chk("res_data", result_data, r.d);
               chk("res_error", 64'(result_error), 64'(r.e));
            end
            pv = result_valid && !result_ready;
            hd = result_data;
            he = result_error;
         end
      end
   end

   // issue a job, wait for acceptance and queue what the bus and result should show
   task automatic issue(input int wi, nw, ei, da, input logic [63:0] k1, k2, k3, d, input logic en,
                        input logic [63:0] rv, output bit ok);
      int    n, np, w, t;
      bit    bad;
      xfer_t x;
      res_t  r;
      @(posedge HCLK);
      #1;
      wait_idx = wi; nwait = nw; err_idx = ei; done_at = da; res_val = rv; xn = 0; pn = 0;
      key1 = k1; key2 = k2; key3 = k3; in_data = d; encr_decr = en;
      start_valid = 1;
      n = 0;
      do begin @(negedge HCLK); n++; end while (!start_ready && n < 200);
      ok = start_ready;
      if (!ok) begin fail("accept_wait"); start_valid = 0; return; end
      t   = cyc;
      bad = ei >= 0 || da >= POLL_MAX;
      np  = da < POLL_MAX ? da + 1 : POLL_MAX;
      n   = ei >= 0 ? ei + 1 : 5 + np + (da < POLL_MAX ? 1 : 0);
      w   = (wi >= 0 && wi < n && wi != ei ? nw : 0) + (ei >= 0 ? 1 : 0);
      for (int i = 0; i < n; i++) begin
         x.wr   = i < 5;
         x.addr = BASE + (i < 5 ? 32'(8 * i) : i < 5 + np ? 32'h28 : 32'h30);
         x.wd   = i == 0 ? k1 : i == 1 ? k2 : i == 2 ? k3 : i == 3 ? d : {62'b0, en, 1'b1};
         exp_bus.push_back(x);
      end
      r.d = bad ? 64'd0 : rv;
      r.e = bad;
      r.t = t + 2 * n + w + 1;
      exp_res.push_back(r);
      @(posedge HCLK);
      #1;
      start_valid = 0;
      key1 = r64(); key2 = r64(); key3 = r64(); in_data = r64(); encr_decr = ~en;
   endtask

   task automatic run_job(input int wi, nw, ei, da, bp, input bit ovr, input logic [63:0] k1, k2, k3, d,
                          input logic en, input logic [63:0] rv);
      int n;
      bit ok;
      result_ready = bp == 0;
      issue(wi, nw, ei, da, k1, k2, k3, d, en, rv, ok);
      if (!ok) return;
      n = 0;
      do begin @(negedge HCLK); n++; end while (!result_valid && n < 3000);
      if (!result_valid) begin fail("result_wait"); result_ready = 1; return; end
      for (int i = 0; i < bp; i++) begin
         if (ovr) begin start_valid = 1; chk("busy_start_ready", 64'(start_ready), 64'd0); end
         if (i == bp - 1) begin @(posedge HCLK); #1 result_ready = 1; start_valid = 0; end
         @(negedge HCLK);
      end
      @(negedge HCLK);
      chk("start_ready_after_resp", 64'(start_ready), 64'd1);
   endtask

   task automatic reset_mid_poll();
      int n;
      bit ok;
      result_ready = 1;
      issue(-1, 0, -1, 1000, r64(), r64(), r64(), r64(), 1'b0, r64(), ok);
      if (!ok) return;
      n = 0;
      do begin @(negedge HCLK); n++; end while (!(dp && pa == BASE + 32'h28 && pn >= 2) && n < 200);
      if (n >= 200) fail("stat_wait");
      @(posedge HCLK);
      #1 HRESET = 0;
      @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_htrans", 64'(HTRANS), 64'd0);
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_result_valid", 64'(result_valid), 64'd0);
      chk("rst_haddr", 64'(HADDR), 64'd0);
      exp_bus.delete();
      exp_res.delete();
      @(posedge HCLK);
      #1 HRESET = 1;
   endtask

   initial begin
      repeat (3) @(negedge HCLK);
      chk("init_htrans", 64'(HTRANS), 64'd0);
      chk("init_haddr", 64'(HADDR), 64'd0);
      chk("init_hwrite", 64'(HWRITE), 64'd0);
      chk("init_hwdata", HWDATA, 64'd0);
      chk("init_result_valid", 64'(result_valid), 64'd0);
      chk("init_result_data", result_data, 64'd0);
      chk("init_result_error", 64'(result_error), 64'd0);
      chk("init_start_ready", 64'(start_ready), 64'd1);
      chk("const_bus", {40'd0, HBURST, HSIZE, HPROT, 7'd0, HMASTLOCK}, {40'd0, 3'b000, 3'b011, 4'b0011, 7'd0, 1'b0});
      @(posedge HCLK);
      #1 HRESET = 1;
      // zero-wait, done on first poll
      run_job(-1, 0, -1, 0, 0, 0, 64'h0123456789ABCDEF, r64(), r64(), 64'h4E6F772069732074, 1'b1, 64'h3FA40E8A984D4815);
      // three wait states in the key2 data phase
      run_job(1, 3, -1, 0, 0, 0, r64(), r64(), r64(), r64(), 1'b0, r64());
      // done on fourth poll
      run_job(-1, 0, -1, 3, 0, 0, r64(), r64(), r64(), r64(), 1'b1, r64());
      // done on the last allowed poll, then a full timeout
      run_job(-1, 0, -1, POLL_MAX - 1, 0, 0, r64(), r64(), r64(), r64(), 1'b0, r64());
      run_job(-1, 0, -1, POLL_MAX, 0, 0, r64(), r64(), r64(), r64(), 1'b1, r64());
      // error on the data write, then a normal job
      run_job(-1, 0, 3, 0, 0, 0, r64(), r64(), r64(), r64(), 1'b1, r64());
      run_job(-1, 0, -1, 2, 0, 0, r64(), r64(), r64(), r64(), 1'b0, r64());
      // backpressure with a competing start request
      run_job(-1, 0, -1, 1, 5, 1, r64(), r64(), r64(), r64(), 1'b1, r64());
      reset_mid_poll();
      run_job(-1, 0, -1, 0, 0, 0, r64(), r64(), r64(), r64(), 1'b1, r64());
      for (int j = 0; j < 20; j++)
         run_job($urandom_range(0, 8), $urandom_range(0, 4),
                 $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 4)) : -1,
                 $urandom_range(0, POLL_MAX + 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 r64(), r64(), r64(), r64(), 1'($urandom_range(0, 1)), r64());
      repeat (5) @(negedge HCLK);
      chk("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
      chk("res_queue_drained", 64'(exp_res.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/des_ahb_master.md
Name: des_ahb_master

Overview:
AHB-Lite single-master initiator that drives the Triple DES AHB-Lite slave subsystem. It accepts one job (3 keys, 64-bit block, encrypt/decrypt) on a valid/ready interface and writes the keys, data and control registers over AHB-Lite. It polls the status register until done, reads the 64-bit result, and returns it with an error flag on a valid/ready result interface. The block sits on the bus master side, facing the slave top level.

Parameters:
BASE_ADDR, 32'h0000_0000, slave base address; all offsets are added to it.
KEY1_OFF, 32'h00, write offset for key1.
KEY2_OFF, 32'h08, write offset for key2.
KEY3_OFF, 32'h10, write offset for key3.
DATA_OFF, 32'h18, write offset for input block.
CTRL_OFF, 32'h20, control write; bit1 = encr_decr, bit0 = start.
STAT_OFF, 32'h28, status read; bit0 = done.
RES_OFF, 32'h30, result read offset.
POLL_MAX, 16, maximum number of status reads before timeout.

Ports:
HCLK  in  1  clock
HRESET  in  1  reset, synchronous, active-low
start_valid  in  1  job request
start_ready  out  1  high only in IDLE
encr_decr  in  1  1 = encrypt, 0 = decrypt; sampled on accept
in_data  in  64  plaintext or ciphertext; sampled on accept
key1, key2, key3  in  64 each  keys; sampled on accept
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_data  out  64  result block
result_error  out  1  job aborted (HRESP error or poll timeout)
HADDR  out  32  address
HWRITE  out  1  write
HTRANS  out  2  IDLE = 00, NONSEQ = 10 only
HBURST  out  3  constant 000 (SINGLE)
HSIZE  out  3  constant 011 (64-bit)
HPROT  out  4  constant 0011
HMASTLOCK  out  1  constant 0
HWDATA  out  64  write data, driven during data phase
HREADY  in  1  transfer complete / bus ready
HRESP  in  1  1 = ERROR
HRDATA  in  64  read data

Behaviour:
- Reset (HRESET low at a HCLK edge): state is IDLE, HTRANS = 00, HADDR = 0, HWRITE = 0, HWDATA = 0, result_valid = 0, result_data = 0, result_error = 0, poll counter = 0. Reset mid-transfer abandons the job immediately.
- Accept: a job is accepted when start_valid && start_ready. All inputs are latched into internal registers.
- Transfer sequence, strictly in order: W_KEY1, W_KEY2, W_KEY3, W_DATA, W_CTRL (HWDATA = {62'b0, encr_decr, 1'b1}), R_STAT (repeated), R_RES.
- Transfers do not overlap:
  - ADDR state: drive HTRANS = NONSEQ, HADDR, HWRITE. Remain in ADDR until an edge with HREADY = 1.
  - DATA state: HTRANS = IDLE. Hold HWDATA stable for writes. The transfer completes on the first edge with HREADY = 1.
- Cycle after accept = first address phase. With a zero-wait slave, each transfer takes 2 cycles.
- Error: HRESP = 1 in a data phase (first cycle, HREADY = 0) forces HTRANS = IDLE for the next address slot. On the edge HREADY = 1 && HRESP = 1, go to RESP with result_error = 1 and result_data = 0. No further transfers are issued.
- Polling: after each R_STAT completes:
  - HRDATA[0] = 1: proceed to R_RES.
  - Otherwise increment the poll counter and issue a new R_STAT.
  - When the counter reaches POLL_MAX with done still 0: go to RESP with result_error = 1.
  - The counter clears on accept.
- R_RES completion: result_data captured from HRDATA on the completing edge. Next cycle: state RESP, result_valid = 1, result_error = 0.
- RESP: result_valid, result_data and result_error are held stable until result_ready = 1, then return to IDLE. start_ready rises the following cycle.
- start_valid is ignored outside IDLE. HRDATA is ignored on write transfers.

Test Plan:
1. Zero-wait slave, done on first poll.
   - Stimulus: job accepted at cycle T; key1 = 64'h0123456789ABCDEF, in_data = 64'h4E6F772069732074, encr_decr = 1; slave returns result 64'h3FA40E8A984D4815.
   - Required: writes at T+1..T+10; CTRL HWDATA = 64'h3; status read completes T+12; result read completes T+14; result_valid = 1 at T+15 with result_data = 64'h3FA40E8A984D4815, result_error = 0.
2. Wait states.
   - Stimulus: slave holds HREADY = 0 for 3 cycles in the W_KEY2 data phase.
   - Required: HWDATA = key2 stable throughout; HTRANS = IDLE; next NONSEQ to BASE + 0x10 only after HREADY = 1.
3. Polling.
   - Stimulus: status returns 0, 0, 0, then 1.
   - Required: exactly 4 R_STAT transfers to BASE + 0x28, then 1 R_RES to BASE + 0x30.
4. Poll timeout.
   - Stimulus: status is always 0, POLL_MAX = 16.
   - Required: 16 status reads, then result_valid = 1, result_error = 1, result_data = 0; no read of RES_OFF.
5. Error response.
   - Stimulus: two-cycle ERROR on W_DATA.
   - Required: no W_CTRL issued; result_error = 1; after result_ready, start_ready = 1 and a new job completes normally.
6. Result backpressure and reset.
   - Stimulus: result_ready held 0 for 5 cycles; a new start_valid is presented meanwhile.
   - Required: result held stable; the new job is not accepted.
   - Stimulus: HRESET low mid-R_STAT.
   - Required: the next edge gives IDLE, HTRANS = 00, start_ready = 1.
